// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: shares the register-file write port among NUM_REQ sources and drops $zero writes.
// Define RFARB_ROUND_ROBIN_EN for rotating priority; otherwise the lowest valid index wins.
module regfile_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic                      WbHold,
    input  logic [NUM_REQ-1:0]        ReqValid,
    input  logic [NUM_REQ*ADDR_W-1:0] ReqReg,
    input  logic [NUM_REQ*DATA_W-1:0] ReqData,
    output logic [NUM_REQ-1:0]        ReqReady,
    output logic                      RegWrite,
    output logic [ADDR_W-1:0]         WriteReg,
    output logic [DATA_W-1:0]         WriteData,
    output logic [$clog2(NUM_REQ)-1:0] GrantId
);

    localparam int ID_W = $clog2(NUM_REQ);

    logic [ADDR_W-1:0] regOf  [NUM_REQ];
    logic [DATA_W-1:0] dataOf [NUM_REQ];

    logic              grantValid;
    logic [ID_W-1:0]   grantIdx;
    logic [ID_W-1:0]   candIdx;
    logic [ADDR_W-1:0] selReg;
    logic [DATA_W-1:0] selData;

    for (genvar g = 0; g < NUM_REQ; g++) begin : gSlice
        assign regOf[g]  = ReqReg[g*ADDR_W +: ADDR_W];
        assign dataOf[g] = ReqData[g*DATA_W +: DATA_W];
    end

`ifdef RFARB_ROUND_ROBIN_EN
    logic [ID_W-1:0] rrPtr;
`endif

    // Grant selection; ReqReady is forced low during reset and hold
    always_comb begin
        ReqReady   = '0;
        grantValid = 1'b0;
        grantIdx   = '0;
        candIdx    = '0;
        selReg     = '0;
        selData    = '0;
        if (!Rst && !WbHold) begin
`ifdef RFARB_ROUND_ROBIN_EN
            for (int k = 0; k < NUM_REQ; k++) begin
                candIdx = ID_W'((int'(rrPtr) + k) % NUM_REQ);
                if (!grantValid && ReqValid[candIdx]) begin
                    grantValid = 1'b1;
                    grantIdx   = candIdx;
                end
            end
`else
            // Scanning downward lets the lowest valid index overwrite the rest
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                candIdx = ID_W'(i);
                if (ReqValid[candIdx]) begin
                    grantValid = 1'b1;
                    grantIdx   = candIdx;
                end
            end
`endif
            if (grantValid) begin
                ReqReady[grantIdx] = 1'b1;
                selReg             = regOf[grantIdx];
                selData            = dataOf[grantIdx];
            end
        end
    end

    // Registered write port; a $zero grant still updates index/data/id but never enables the write
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            RegWrite  <= 1'b0;
            WriteReg  <= '0;
            WriteData <= '0;
            GrantId   <= '0;
        end else if (grantValid) begin
            RegWrite  <= (selReg != '0);
            WriteReg  <= selReg;
            WriteData <= selData;
            GrantId   <= grantIdx;
        end else begin
            RegWrite  <= 1'b0;
        end
    end

`ifdef RFARB_ROUND_ROBIN_EN
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            rrPtr <= '0;
        end else if (grantValid) begin
            rrPtr <= (grantIdx == ID_W'(NUM_REQ - 1)) ? '0 : grantIdx + 1'b1;
        end
    end
`endif

endmodule
